// File: rtl/demux4e_deser_pkg.sv
// Shared constants and FSM state type for the 1:4 enable demux / deserializer.
package demux4_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } st_t;

    // Round-robin pointer advance; wraps modulo LANES by width.
    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] one;
        one = {{(SEL_W-1){1'b0}}, 1'b1};
        return p + one;
    endfunction

endpackage

// File: rtl/demux4e_deser_if.sv
// Sample-in / lane-out bundle for demux4e_deser.
// Optional parity output is present only when DEMUX4_PARITY_EN is defined.
interface demux4e_deser_if
    import demux4_pkg::*;
#(
    parameter int W = 1
);
    logic                 e;
    logic [W-1:0]         d;
    logic                 dv;
    logic                 rdy;
    logic                 mode;
    logic [SEL_W-1:0]     s;
    logic [LANES*W-1:0]   y;
    logic [LANES-1:0]     yv;
    logic                 fr;
    logic                 ack;
    logic [SEL_W-1:0]     ptr;
`ifdef DEMUX4_PARITY_EN
    logic                 par;

    modport master (
        output e, d, dv, mode, s, ack,
        input  rdy, y, yv, fr, ptr, par
    );
    modport slave (
        input  e, d, dv, mode, s, ack,
        output rdy, y, yv, fr, ptr, par
    );
`else
    modport master (
        output e, d, dv, mode, s, ack,
        input  rdy, y, yv, fr, ptr
    );
    modport slave (
        input  e, d, dv, mode, s, ack,
        output rdy, y, yv, fr, ptr
    );
`endif
endinterface

// File: rtl/demux4e_deser_dec2to4_e.sv
// Combinational 2:4 one-hot decoder with enable; all outputs low when en=0.
module dec2to4_e
    import demux4_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] a,
    output logic [LANES-1:0] o
);

    always_comb begin
        o = '0;
        if (en) begin
            o[a] = 1'b1;
        end
    end

endmodule

// File: rtl/demux4e_deser.sv
// Sequential 1:4 demux with enable: addressed lane writes or round-robin frame
// assembly with READY/ACK release. Parity output under DEMUX4_PARITY_EN.
//
// state | meaning
// IDLE  | frame mode waiting for lane 0 (also the resting state in addressed mode)
// FILL  | frame mode, lanes 1..3 being filled at ptr
// FULL  | frame held for consumer; input stalled until ack
module demux4e_deser
    import demux4_pkg::*;
#(
    parameter int W = 1
)(
    input  logic            clk,
    input  logic            rst_n,
    demux4e_deser_if.slave  bus
);

    st_t                state, state_nxt;
    logic [SEL_W-1:0]   ptr_q, ptr_nxt;
    logic [SEL_W-1:0]   lane_sel, lane_q;
    logic [LANES-1:0]   we, yv_c;
    logic [LANES*W-1:0] y_q, y_nxt;
    logic               rdy_c, acc, wr_q, fr_q;

    assign rdy_c    = (state != FULL);
    assign acc      = bus.e & bus.dv & rdy_c;
    assign lane_sel = bus.mode ? ptr_q : bus.s;

    dec2to4_e u_dec_we (
        .en (acc),
        .a  (lane_sel),
        .o  (we)
    );

    // Strobe is rebuilt from the registered write, so it lands with the new lane data.
    dec2to4_e u_dec_yv (
        .en (wr_q),
        .a  (lane_q),
        .o  (yv_c)
    );

    always_comb begin
        y_nxt = y_q;
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) begin
                y_nxt[k*W +: W] = bus.d;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr_q;
        if (!bus.mode) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        ptr_nxt   = ptr_inc(ptr_q);
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    if (acc) begin
                        ptr_nxt = ptr_inc(ptr_q);
                        if (ptr_q == '1) begin
                            state_nxt = FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.ack) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr_q  <= '0;
            y_q    <= '0;
            wr_q   <= 1'b0;
            lane_q <= '0;
            fr_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr_q  <= ptr_nxt;
            y_q    <= y_nxt;
            wr_q   <= acc;
            lane_q <= lane_sel;
            fr_q   <= (state_nxt == FULL);
        end
    end

`ifdef DEMUX4_PARITY_EN
    logic par_q;
    logic par_upd;

    // Frame mode refreshes parity only as the frame completes; addressed mode on every write.
    assign par_upd = bus.mode ? ((state_nxt == FULL) && (state != FULL)) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (par_upd) begin
            par_q <= ^y_nxt;
        end
    end

    assign bus.par = par_q;
`endif

    assign bus.rdy = rdy_c;
    assign bus.y   = y_q;
    assign bus.yv  = yv_c;
    assign bus.fr  = fr_q;
    assign bus.ptr = ptr_q;

endmodule

// File: tb/tb_demux4e_deser.sv
// Directed-vector bench for demux4e_deser (W=4); parity checks under DEMUX4_PARITY_EN.
module tb_demux4e_deser;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux4e_deser_if #(.W(4)) bus ();

    demux4e_deser #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic dv, input logic mode,
                         input logic [1:0] s, input logic [3:0] d, input logic ack);
        bus.e    = e;
        bus.dv   = dv;
        bus.mode = mode;
        bus.s    = s;
        bus.d    = d;
        bus.ack  = ack;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        #2;
        chk("rst_y",   32'(bus.y),   32'h0);
        chk("rst_yv",  32'(bus.yv),  32'h0);
        chk("rst_fr",  32'(bus.fr),  32'h0);
        chk("rst_ptr", 32'(bus.ptr), 32'h0);
        chk("rst_rdy", 32'(bus.rdy), 32'h1);
`ifdef DEMUX4_PARITY_EN
        chk("rst_par", 32'(bus.par), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // addressed mode
        drive(1'b1, 1'b1, 1'b0, 2'd2, 4'hA, 1'b0);
        tick();
        chk("a_lane2_y",  32'(bus.y),  32'h0A00);
        chk("a_lane2_yv", 32'(bus.yv), 32'b0100);
        chk("a_lane2_fr", 32'(bus.fr), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 4'h5, 1'b0);
        tick();
        chk("a_en0_y",  32'(bus.y),  32'h0A00);
        chk("a_en0_yv", 32'(bus.yv), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 4'hF, 1'b0);
        tick();
        chk("a_lane3_y",  32'(bus.y),  32'hFA00);
        chk("a_lane3_yv", 32'(bus.yv), 32'b1000);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h7, 1'b0);
        tick();
        chk("a_lane0_y",  32'(bus.y),   32'hFA07);
        chk("a_lane0_yv", 32'(bus.yv),  32'b0001);
        chk("a_rdy",      32'(bus.rdy), 32'h1);
        chk("a_ptr",      32'(bus.ptr), 32'h0);
`ifdef DEMUX4_PARITY_EN
        chk("a_par", 32'(bus.par), 32'h1);
`endif
        drive(1'b1, 1'b0, 1'b0, 2'd1, 4'h3, 1'b0);
        tick();
        chk("a_dv0_y",  32'(bus.y),  32'hFA07);
        chk("a_dv0_yv", 32'(bus.yv), 32'h0);

        // frame mode, full frame
        drive(1'b1, 1'b1, 1'b1, 2'd3, 4'h1, 1'b0);
        tick();
        chk("f1_ptr", 32'(bus.ptr), 32'h1);
        chk("f1_yv",  32'(bus.yv),  32'b0001);
        bus.d = 4'h2;
        tick();
        bus.d = 4'h3;
        tick();
        chk("f3_ptr", 32'(bus.ptr), 32'h3);
        chk("f3_fr",  32'(bus.fr),  32'h0);
        bus.d = 4'h4;
        tick();
        chk("f4_y",   32'(bus.y),   32'h4321);
        chk("f4_fr",  32'(bus.fr),  32'h1);
        chk("f4_rdy", 32'(bus.rdy), 32'h0);
        chk("f4_ptr", 32'(bus.ptr), 32'h0);
        chk("f4_yv",  32'(bus.yv),  32'b1000);
`ifdef DEMUX4_PARITY_EN
        chk("f4_par", 32'(bus.par), 32'h1);
`endif
        bus.d = 4'h9;
        tick();
        chk("full_dv_y",  32'(bus.y),  32'h4321);
        chk("full_dv_fr", 32'(bus.fr), 32'h1);
        chk("full_dv_yv", 32'(bus.yv), 32'h0);
        bus.ack = 1'b1;
        tick();
        chk("ack_fr",  32'(bus.fr),  32'h0);
        chk("ack_rdy", 32'(bus.rdy), 32'h1);
        chk("ack_y",   32'(bus.y),   32'h4321);
        chk("ack_yv",  32'(bus.yv),  32'h0);
        bus.ack = 1'b0;

        // partial frame abandoned by mode switch
        drive(1'b1, 1'b1, 1'b1, 2'd0, 4'h7, 1'b0);
        tick();
        bus.d = 4'h8;
        tick();
        chk("p_ptr", 32'(bus.ptr), 32'h2);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        tick();
        chk("sw_ptr", 32'(bus.ptr), 32'h0);
        chk("sw_fr",  32'(bus.fr),  32'h0);
        chk("sw_y",   32'(bus.y),   32'h4387);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 4'hC, 1'b0);
        tick();
        chk("re_y",   32'(bus.y),   32'h438C);
        chk("re_ptr", 32'(bus.ptr), 32'h1);
        bus.d = 4'h5;
        tick();
        chk("pre_rst_ptr", 32'(bus.ptr), 32'h2);
        chk("pre_rst_y",   32'(bus.y),   32'h435C);

        // asynchronous reset mid-fill
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y",   32'(bus.y),   32'h0);
        chk("arst_ptr", 32'(bus.ptr), 32'h0);
        chk("arst_fr",  32'(bus.fr),  32'h0);
        chk("arst_rdy", 32'(bus.rdy), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 1'b0);
        tick();
        bus.d = 4'h0;
        tick();
        bus.d = 4'h3;
        tick();
        bus.d = 4'h3;
        tick();
        chk("rf_y",  32'(bus.y),  32'h3300);
        chk("rf_fr", 32'(bus.fr), 32'h1);
`ifdef DEMUX4_PARITY_EN
        chk("rf_par", 32'(bus.par), 32'h0);
`endif

        // ack honoured with e=0
        drive(1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0);
        tick();
        chk("hold_fr", 32'(bus.fr), 32'h1);
        bus.ack = 1'b1;
        tick();
        chk("ack_e0_fr",  32'(bus.fr),  32'h0);
        chk("ack_e0_rdy", 32'(bus.rdy), 32'h1);
        bus.ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
